// File: rtl/calc_entry_ctrl.sv
// Calculator entry sequencer: captures A, B and the op on successive Enter presses,
// drives the math unit, waits a settle window and registers its answer.
module calc_entry_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       power_on,
    input  logic       key_enter,
    input  logic       key_clear,
    input  logic [6:0] din,
    input  logic [1:0] op_sel,
    input  logic [6:0] ans_in,
    output logic       on_off,
    output logic [6:0] op_a,
    output logic [6:0] op_b,
    output logic [3:0] op_onehot,
    output logic [6:0] result,
    output logic       result_valid,
    output logic       div_err,
    output logic [2:0] state_led
);

    // state      | meaning
    // S_OFF      | math unit unpowered, waiting for power_on
    // S_ENTER_A  | waiting for Enter to capture operand A
    // S_ENTER_B  | waiting for Enter to capture operand B
    // S_ENTER_OP | waiting for Enter to capture the operation
    // S_EXEC     | op-select driven, settle counter running
    // S_SHOW     | answer registered and displayed
    typedef enum logic [2:0] {
        S_OFF      = 3'd0,
        S_ENTER_A  = 3'd1,
        S_ENTER_B  = 3'd2,
        S_ENTER_OP = 3'd3,
        S_EXEC     = 3'd4,
        S_SHOW     = 3'd5
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic       enter_q, clear_q;
    logic [6:0] op_a_q, op_a_d;
    logic [6:0] op_b_q, op_b_d;
    logic [1:0] op_q, op_d;
    logic [3:0] cnt_q, cnt_d;
    logic [6:0] result_q, result_d;
    logic       valid_q, valid_d;
    logic       div_err_q, div_err_d;
    logic       enter_ev, clear_ev;

    assign enter_ev = key_enter & ~enter_q;
    assign clear_ev = key_clear & ~clear_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_OFF;
            enter_q   <= 1'b0;
            clear_q   <= 1'b0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            op_q      <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            valid_q   <= 1'b0;
            div_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            enter_q   <= key_enter;
            clear_q   <= key_clear;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
            div_err_q <= div_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        valid_d   = valid_q;
        div_err_d = div_err_q;

        if (!power_on) begin
            state_d   = S_OFF;
            op_a_d    = '0;
            op_b_d    = '0;
            result_d  = '0;
            valid_d   = 1'b0;
            div_err_d = 1'b0;
        end else if (state_q == S_OFF) begin
            state_d = S_ENTER_A;
        end else if (clear_ev) begin
            // result is deliberately kept so the display survives a clear
            state_d   = S_ENTER_A;
            op_a_d    = '0;
            op_b_d    = '0;
            valid_d   = 1'b0;
            div_err_d = 1'b0;
        end else begin
            case (state_q)
                S_ENTER_A: if (enter_ev) begin
                    op_a_d  = din;
                    state_d = S_ENTER_B;
                end
                S_ENTER_B: if (enter_ev) begin
                    op_b_d  = din;
                    state_d = S_ENTER_OP;
                end
                S_ENTER_OP: if (enter_ev) begin
                    op_d      = op_sel;
                    cnt_d     = CNT_LOAD;
                    div_err_d = (op_sel == 2'd3) && (op_b_q == 7'd0);
                    state_d   = S_EXEC;
                end
                S_EXEC: begin
                    if (cnt_q == 4'd0) begin
                        result_d = div_err_q ? 7'd0 : ans_in;
                        valid_d  = 1'b1;
                        state_d  = S_SHOW;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                S_SHOW: if (enter_ev) begin
                    valid_d = 1'b0;
                    state_d = S_ENTER_A;
                end
                default: state_d = S_OFF;
            endcase
        end
    end

    assign on_off       = (state_q != S_OFF);
    assign op_a         = op_a_q;
    assign op_b         = op_b_q;
    assign op_onehot    = (state_q == S_EXEC || state_q == S_SHOW) ? (4'b0001 << op_q) : 4'b0000;
    assign result       = result_q;
    assign result_valid = valid_q;
    assign div_err      = div_err_q;
    assign state_led    = state_q;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Bench for calc_entry_ctrl: behavioural math unit on ans_in, expected answers
// queued at the op Enter and compared when result_valid rises.
module tb_calc_entry_ctrl;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst, power_on, key_enter, key_clear;
    logic [6:0] din;
    logic [1:0] op_sel;
    logic [6:0] ans_in;
    logic       on_off;
    logic [6:0] op_a, op_b;
    logic [3:0] op_onehot;
    logic [6:0] result;
    logic       result_valid, div_err;
    logic [2:0] state_led;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];   // {div_err, result}
    logic [6:0] last_res;

    calc_entry_ctrl #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .power_on(power_on), .key_enter(key_enter),
        .key_clear(key_clear), .din(din), .op_sel(op_sel), .ans_in(ans_in),
        .on_off(on_off), .op_a(op_a), .op_b(op_b), .op_onehot(op_onehot),
        .result(result), .result_valid(result_valid), .div_err(div_err),
        .state_led(state_led)
    );

    always #5 clk = ~clk;

    // math unit stand-in; divide by zero returns all ones
    always_comb begin
        ans_in = 7'd0;
        case (op_onehot)
            4'b0001: ans_in = 7'(op_a + op_b);
            4'b0010: ans_in = 7'(op_a - op_b);
            4'b0100: ans_in = 7'(op_a * op_b);
            4'b1000: ans_in = (op_b == 7'd0) ? 7'd127 : 7'(op_a / op_b);
            default: ans_in = 7'd0;
        endcase
    end

    function automatic logic [7:0] expect_of(int a, int b, int op);
        case (op)
            0:       return {1'b0, 7'(a + b)};
            1:       return {1'b0, 7'(a - b)};
            2:       return {1'b0, 7'(a * b)};
            default: return (b == 0) ? 8'h80 : {1'b0, 7'(a / b)};
        endcase
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [6:0] val);
        din       = val;
        key_enter = 1'b1;
        step();
        key_enter = 1'b0;
        step();
    endtask

    // op Enter, then wait (bounded) for result_valid and score against the queue
    task automatic run_op(input int a, input int b, input int op, input logic [3:0] oh);
        int         n;
        logic [7:0] e;
        op_sel    = 2'(op);
        exp_q.push_back(expect_of(a, b, op));
        key_enter = 1'b1;
        step();
        key_enter = 1'b0;
        chk("exec_state", state_led, 4);
        n = 0;
        while (!result_valid && n < 40) begin
            chk("exec_onehot", op_onehot, oh);
            step();
            n++;
        end
        chk("latency", n + 1, S + 1);
        e = exp_q.pop_front();
        chk("result", result, e[6:0]);
        chk("div_err", div_err, e[7]);
        chk("valid", result_valid, 1);
        chk("show_state", state_led, 5);
        chk("show_onehot", op_onehot, oh);
        last_res = e[6:0];
    endtask

    initial begin
        rst = 1'b1; power_on = 1'b0; key_enter = 1'b0; key_clear = 1'b0;
        din = '0; op_sel = '0;
        step(); step();
        chk("rst_state", state_led, 0);
        chk("rst_on_off", on_off, 0);
        chk("rst_result", result, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_op_a", op_a, 0);
        chk("rst_onehot", op_onehot, 0);

        rst = 1'b0; power_on = 1'b1;
        step();
        chk("pwr_state", state_led, 1);
        chk("pwr_on_off", on_off, 1);

        // add 12 + 5
        press(7'd12);
        chk("a_state", state_led, 2);
        chk("a_val", op_a, 12);
        press(7'd5);
        chk("b_state", state_led, 3);
        chk("b_val", op_b, 5);
        chk("entry_onehot", op_onehot, 0);
        run_op(12, 5, 0, 4'b0001);

        // restart from SHOW
        press(7'd0);
        chk("rs_state", state_led, 1);
        chk("rs_valid", result_valid, 0);
        chk("rs_result", result, 17);
        chk("rs_onehot", op_onehot, 0);

        // held Enter in ENTER_A
        din = 7'd3; key_enter = 1'b1;
        step();
        chk("hold_first", state_led, 2);
        for (int i = 0; i < 9; i++) step();
        key_enter = 1'b0;
        step();
        chk("hold_state", state_led, 2);
        chk("hold_op_a", op_a, 3);
        chk("hold_op_b", op_b, 5);
        press(7'd4);
        run_op(3, 4, 2, 4'b0100);

        // sub 20 - 7
        press(7'd0); press(7'd20); press(7'd7);
        run_op(20, 7, 1, 4'b0010);

        // div 100 / 7 and divide by zero
        press(7'd0); press(7'd100); press(7'd7);
        run_op(100, 7, 3, 4'b1000);
        press(7'd0); press(7'd9); press(7'd0);
        run_op(9, 0, 3, 4'b1000);

        // clear and enter together in ENTER_OP
        press(7'd0); press(7'd6); press(7'd2);
        chk("ce_pre", state_led, 3);
        key_clear = 1'b1; key_enter = 1'b1;
        step();
        chk("ce_state", state_led, 1);
        chk("ce_op_a", op_a, 0);
        chk("ce_op_b", op_b, 0);
        chk("ce_div_err", div_err, 0);
        chk("ce_result", result, last_res);
        key_clear = 1'b0; key_enter = 1'b0;
        step();
        chk("ce_no_exec", state_led, 1);

        // power off on the 2nd EXEC cycle
        press(7'd6); press(7'd2);
        op_sel = 2'd0; key_enter = 1'b1;
        step();
        key_enter = 1'b0;
        step();
        chk("po_in_exec", state_led, 4);
        power_on = 1'b0;
        step();
        chk("po_state", state_led, 0);
        chk("po_on_off", on_off, 0);
        chk("po_onehot", op_onehot, 0);
        chk("po_result", result, 0);
        chk("po_valid", result_valid, 0);
        chk("po_op_a", op_a, 0);
        power_on = 1'b1;
        step();
        chk("po_restart", state_led, 1);
        chk("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/calc_entry_ctrl.md
Name: calc_entry_ctrl

Overview:
- Sequential front end that drives the calculator math unit.
- Captures operand A, operand B and the operation from the board switches, one Enter press per step.
- Drives the math unit's power gate, operand buses and one-hot op-select lines, waits a settle window, then registers the returned 7-bit answer for display.
- Sits between the debounced board inputs and the combinational math/sign unit.

Parameters:
- SETTLE_CYCLES, 4, number of clock cycles op-select is held before the answer is sampled; legal range 1..15.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- power_on  input  1  level; low forces the block off
- key_enter  input  1  debounced, synchronised Enter key (level)
- key_clear  input  1  debounced, synchronised Clear key (level)
- din  input  7  switch value for operand entry
- op_sel  input  2  operation code: 0 add, 1 sub, 2 mul, 3 div
- ans_in  input  7  answer returned by the math unit
- on_off  output  1  power gate to the math unit
- op_a  output  7  operand A to the math unit
- op_b  output  7  operand B to the math unit
- op_onehot  output  4  op-select lines to the math unit; bit n = op code n
- result  output  7  registered answer
- result_valid  output  1  result holds the current calculation
- div_err  output  1  last calculation was a divide by zero
- state_led  output  3  current state encoding, for LEDs

Behaviour:
- Reset (rst high at a clk edge):
  - State goes to OFF.
  - All outputs and internal registers go to 0, including the enter/clear edge registers.
- States and encodings: OFF=0, ENTER_A=1, ENTER_B=2, ENTER_OP=3, EXEC=4, SHOW=5. state_led carries the encoding.
- Edge detection:
  - enter_q registers key_enter each cycle.
  - enter_ev = key_enter & ~enter_q, so a held key produces exactly one event.
  - Clear uses the same scheme (clear_ev).
- Event priority, highest first: rst, then power_on low, then clear_ev, then enter_ev.
- OFF:
  - on_off=0.
  - When power_on=1, go to ENTER_A on the next edge.
- power_on low in any state: go to OFF on that edge and clear op_a, op_b, result, result_valid and div_err.
- clear_ev in any powered state:
  - Go to ENTER_A and clear op_a, op_b, result_valid and div_err.
  - result keeps its value.
- ENTER_A: on enter_ev, op_a <= din and go to ENTER_B.
- ENTER_B: on enter_ev, op_b <= din and go to ENTER_OP.
- ENTER_OP:
  - On enter_ev, latch op_sel into an internal op register, load the settle counter with SETTLE_CYCLES-1 and go to EXEC.
  - Also latch div_err <= (op_sel==3 && op_b==0).
- EXEC:
  - op_onehot = one-hot of the latched op.
  - The counter decrements each cycle.
  - On the edge where the counter reads 0: result <= (div_err ? 0 : ans_in), result_valid <= 1, go to SHOW.
  - EXEC therefore lasts exactly SETTLE_CYCLES cycles.
  - enter_ev is ignored in EXEC; clear_ev and power_on low still act.
- SHOW:
  - op_onehot is held, and result and result_valid are held.
  - On enter_ev: result_valid <= 0, op_onehot <= 0, go to ENTER_A. result keeps its value.
- op_onehot is 0 in every state except EXEC and SHOW, so the math unit outputs 0 during entry.
- on_off = 1 in every state except OFF.
- op_a and op_b are registered and stable from capture until the next clear, power-off or reset.
- Latency: the state changes on the same clk edge at which key_enter is first sampled high.
- Latency from the ENTER_OP Enter edge to result_valid high is SETTLE_CYCLES+1 edges.
- Widths: all data is 7-bit unsigned. No arithmetic is done here beyond the 4-bit down counter.

Test Plan:
- Add: reset, power_on=1; enter din=12, then din=5, then op_sel=0 (bench math model returns 17) -> op_onehot=0001 throughout EXEC; result=17 and result_valid=1 exactly SETTLE_CYCLES+1 edges after the op Enter; state_led=5.
- Held key: hold key_enter high for 10 cycles in ENTER_A with din=3 -> single transition to ENTER_B; op_a=3; op_b unchanged.
- Divide by zero: A=9, B=0, op_sel=3 with the model driving ans_in=127 -> div_err=1, result=0, result_valid=1.
- Clear and enter together: in ENTER_OP, key_clear and key_enter rise on the same cycle -> state ENTER_A; op_a=op_b=0; no EXEC entry.
- Power-off mid-EXEC: drop power_on on the 2nd EXEC cycle -> next state OFF; on_off=0; op_onehot=0; result=0; result_valid=0.
- Restart from SHOW: Enter in SHOW holding result=17 -> state ENTER_A; result_valid=0; result stays 17; op_onehot=0.
